data_memory_sized: RTL
======================

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of 64-bit doublewords stored; SHALL be a power of two >= 2.
REQ-002 Parameter ADDR_WIDTH, default 64, meaning byte-address width of MemAddr.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge except on reset.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 MemWrite  input  1  store request.
REQ-006 MemRead  input  1  load request.
REQ-007 MemAddr  input  ADDR_WIDTH  byte address.
REQ-008 WriteData  input  64  store data; the low bytes are used for sub-doubleword sizes.
REQ-009 MemSize  input  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
REQ-010 MemUnsigned  input  1  load extension: 1 zero-extend, 0 sign-extend; ignored for doubleword.
REQ-011 ReadData  output  64  registered load result.
REQ-012 ReadValid  output  1  one-cycle pulse; ReadData is valid.
REQ-013 Ready  output  1  high when the memory accepts requests.
REQ-014 Fault  output  1  one-cycle pulse; the previous-cycle request was rejected.

Function
REQ-015 Addressing SHALL be little-endian byte addressing: doubleword index = MemAddr[log2(DEPTH)+2:3], byte offset = MemAddr[2:0].
REQ-016 The FSM SHALL have two states, CLEAR and IDLE; reset SHALL enter CLEAR with the clear counter at 0.
REQ-017 In CLEAR, one doubleword per cycle SHALL be zeroed at the counter index, counter incrementing; after index DEPTH-1 is zeroed the FSM SHALL move to IDLE (DEPTH cycles total).
REQ-018 Ready SHALL be 0 in CLEAR and 1 in IDLE; requests during CLEAR SHALL be ignored (no write, no ReadValid, no Fault).
REQ-019 A request SHALL be misaligned when the byte offset is not a multiple of the size in bytes (1/2/4/8).
REQ-020 A request SHALL be out of range when MemAddr >= DEPTH*8.
REQ-021 A misaligned or out-of-range request (MemRead or MemWrite high in IDLE) SHALL pulse Fault the next cycle, leave memory unchanged, and not pulse ReadValid.
REQ-022 Store: in IDLE with MemWrite=1 and no fault, only the 1/2/4/8 addressed bytes SHALL be written at the rising edge from WriteData[8*size-1:0]; other bytes SHALL be preserved.
REQ-023 Load: in IDLE with MemRead=1, MemWrite=0 and no fault, ReadData SHALL be updated the next cycle (latency 1), with ReadValid=1 for that cycle only.
REQ-024 Load data SHALL be the addressed bytes placed at bit 0, sign- or zero-extended to 64 bits per MemUnsigned.
REQ-025 When MemRead=1 and MemWrite=1 together, the write SHALL take priority: the store executes, no load occurs, ReadValid=0.
REQ-026 A load issued the cycle after a store to the same bytes SHALL return the newly stored data.
REQ-027 ReadData SHALL hold its last value in cycles without a completed load.
REQ-028 Back-to-back loads SHALL be accepted every cycle, each producing ReadValid one cycle later.

Reset
REQ-029 While rst=0: ReadData=0, ReadValid=0, Fault=0, Ready=0, state=CLEAR, counter=0, regardless of clock.
REQ-030 A reset asserted mid-CLEAR or mid-access SHALL abort it; an in-flight load SHALL produce no ReadValid, and the clear SHALL restart from index 0 after release.
REQ-031 Memory contents need not survive reset; after clear completes, all bytes SHALL read 0.

Verification
REQ-032 Reset/clear: rst=0 for 2 cycles, then release -> Ready=0 for exactly 64 cycles (DEPTH=64), then 1; LD at 8 -> ReadData=0, ReadValid one cycle later.
REQ-033 Doubleword: SD 99 at 56, then LD at 56 next cycle -> ReadData=99; SD 31 at 8 with MemRead also high -> no ReadValid; LD at 8 -> 31.
REQ-034 Byte/extension: SB 0x80 at 10 -> LB at 10 = 0xFFFFFFFFFFFFFF80; LBU at 10 = 0x80; LD at 8 = 0x0000000000800000.
REQ-035 Half/word: SH 0x8001 at 4 -> LHU at 4 = 0x8001; LW at 4 = 0x0000000000008001; LH at 4 = 0xFFFFFFFFFFFF8001.
REQ-036 Faults: LW at 6 -> Fault pulse, no ReadValid; SD at 12 -> Fault, LD at 8 unchanged; LD at 512 (DEPTH=64) -> Fault.
REQ-037 Reset mid-clear at cycle 20 -> clear restarts; Ready rises 64 cycles after the second release.

Source files
------------

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressable doubleword memory with power-up clear, sized loads/stores and fault reporting
module data_memory_sized #(
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic [63:0]           WriteData,
  input  logic [1:0]            MemSize,
  input  logic                  MemUnsigned,
  output logic [63:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Ready,
  output logic                  Fault
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 8);
  localparam logic CLEAR = 1'b0;
  localparam logic IDLE = 1'b1;

  logic          state;
  logic [IW-1:0] clrIdx;
  logic [63:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic [2:0]    offset;
  logic [5:0]    shamt;
  logic [2:0]    alignMask;
  logic [7:0]    byteMask;
  logic [63:0]   bitMask;
  logic [63:0]   raw;
  logic [63:0]   loadVal;
  logic          bad;
  logic          request;
  logic          doStore;
  logic          doLoad;

  assign idx     = MemAddr[IW+2:3];
  assign offset  = MemAddr[2:0];
  assign shamt   = {offset, 3'b000};
  assign Ready   = state == IDLE;
  assign request = Ready && (MemRead || MemWrite);
  assign doStore = Ready && MemWrite && !bad;
  assign doLoad  = Ready && MemRead && !MemWrite && !bad;
  assign raw     = mem[idx] >> shamt;

  genvar b;
  for (b = 0; b < 8; b++) begin : g_mask
    assign bitMask[8*b +: 8] = {8{byteMask[b]}};
  end

  // Decode access size into alignment check, byte lanes and the extended load value
  always_comb begin
    alignMask = MemSize == 2'b11 ? 3'b111 : MemSize == 2'b10 ? 3'b011 : MemSize == 2'b01 ? 3'b001 : 3'b000;
    byteMask  = (MemSize == 2'b11 ? 8'hFF : MemSize == 2'b10 ? 8'h0F : MemSize == 2'b01 ? 8'h03 : 8'h01) << offset;
    bad       = |(offset & alignMask) || MemAddr >= LIMIT;
    loadVal   = MemSize == 2'b11 ? raw :
                MemSize == 2'b10 ? {{32{!MemUnsigned && raw[31]}}, raw[31:0]} :
                MemSize == 2'b01 ? {{48{!MemUnsigned && raw[15]}}, raw[15:0]} :
                                   {{56{!MemUnsigned && raw[7]}}, raw[7:0]};
  end

  // Clear sequencer: walk every doubleword once after reset, then accept requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else if (state == CLEAR) begin
      clrIdx <= clrIdx + 1'b1;
      state  <= clrIdx == IW'(DEPTH - 1) ? IDLE : CLEAR;
    end
  end

  // Storage: zero fill while clearing, otherwise merge the addressed byte lanes of a store
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clrIdx] <= '0;
    else if (doStore)
      mem[idx] <= (mem[idx] & ~bitMask) | ((WriteData << shamt) & bitMask);
  end

  // Response registers: load data held between loads, single-cycle valid and fault pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
      Fault     <= 1'b0;
    end else begin
      ReadValid <= doLoad;
      Fault     <= request && bad;
      if (doLoad)
        ReadData <= loadVal;
    end
  end
endmodule
